wbu_wbuf_arb: RTL and testbench
===============================

// Module: wbu_wbuf_arb
// PURPOSE
//  Parametrised write-back unit: arbitrates NSRC producers (MAU load, ALU, CSR, ...) onto the single
//  regfile write port through a DEPTH-entry write buffer. Removes cycle-count gating so pipelined
//  producers can issue back-to-back. Offers a read-side forwarding lookup of pending writes so
//  decode can bypass data not yet committed to the regfile.
// PARAMETERS
//  DW     32  data width of a register write
//  AW     5   register address width
//  NSRC   2   number of write sources (>=1)
//  DEPTH  4   write-buffer entries (power of two, >=2)
//  FWD_EN 1   1 = forwarding lookup active; 0 = fwd_hit tied 0, fwd_data tied 0
// PORTS
//  hclk        in   1                 clock, rising edge
//  hrstn       in   1                 async active-low reset
//  src_valid   in   NSRC              source i has a write request
//  src_ready   out  NSRC              source i request accepted this cycle
//  src_rd      in   NSRC*AW           dest reg of source i, slice [i*AW +: AW]
//  src_data    in   NSRC*DW           write data of source i, slice [i*DW +: DW]
//  reg_wen     out  1                 regfile write enable
//  reg_waddr   out  AW                regfile write address
//  reg_wdata   out  DW                regfile write data
//  reg_wready  in   1                 regfile accepts the write this cycle
//  fwd_raddr   in   AW                lookup address
//  fwd_hit     out  1                 a pending write to fwd_raddr exists
//  fwd_data    out  DW                data of the youngest matching pending write
//  buf_count   out  $clog2(DEPTH+1)   occupied entries
//  buf_full    out  1                 buf_count == DEPTH
//  buf_empty   out  1                 buf_count == 0
// BEHAVIOUR
//  - Single clock hclk; asynchronous active-low reset hrstn.
//  - Reset: rd/wr pointers, count, rr_ptr = 0; reg_wen=0, reg_waddr=0, reg_wdata=0, fwd_hit=0,
//    fwd_data=0, src_ready=0, buf_empty=1, buf_full=0. Reset mid-operation drops all pending entries.
//  - Arbitration: round-robin over valid sources starting at rr_ptr; at most one grant per cycle.
//    src_ready[i] = grant[i] & ~buf_full (combinational). Handshake = src_valid[i] & src_ready[i].
//    After a handshake, rr_ptr <= (granted index + 1) mod NSRC; otherwise unchanged.
//  - Push: handshake with src_rd != 0 writes {rd,data} at wr_ptr on the edge; wr_ptr wraps mod DEPTH.
//    Handshake with src_rd == 0 completes (source released) but nothing is enqueued.
//  - Output: reg_wen = ~buf_empty; reg_waddr/reg_wdata = head entry when reg_wen, else 0.
//    Pop on edge when reg_wen & reg_wready; rd_ptr wraps mod DEPTH.
//  - Latency: push at edge N into empty buffer -> reg_wen=1 in cycle after N (1 cycle).
//  - Simultaneous push+pop (not full): both occur, count unchanged. When full no push is accepted even if
//    a pop occurs that cycle (ready depends on registered full only).
//  - reg_wready=0 holds head and outputs stable; entries are committed strictly in acceptance order.
//  - Forwarding (combinational): fwd_hit=1 iff FWD_EN and fwd_raddr != 0 and some valid entry matches;
//    fwd_data = data of youngest matching entry (closest to wr_ptr); 0 on miss. Same-cycle incoming
//    request is not visible; head being popped this cycle is still visible.
//  - count width rule: buf_count ranges 0..DEPTH inclusive, never wraps.
// TESTING
//  - Reset: assert hrstn=0 with 3 entries buffered -> all outputs 0, buf_empty=1 immediately (async).
//  - Single write: src0 rd=5 data=0xDEADBEEF, reg_wready=1 -> next cycle reg_wen=1, waddr=5,
//    wdata=0xDEADBEEF; following cycle reg_wen=0, waddr=0.
//  - Round-robin: both sources valid every cycle, reg_wready=1 -> grants alternate 0,1,0,1; commit order matches.
//  - Full/backpressure: reg_wready=0, push 4 writes -> buf_full=1, src_ready=0 on 5th; release ->
//    4 commits in order, one per cycle.
//  - x0 drop: src0 rd=0 data=0x1234 -> src_ready=1, buf_count stays 0, no reg_wen.
//  - Forwarding: buffer rd=7 0x11 then rd=7 0x22, reg_wready=0, fwd_raddr=7 -> fwd_hit=1, fwd_data=0x22;
//    fwd_raddr=0 -> fwd_hit=0.

Source files
------------

// File: rtl/wbu_wbuf_arb.sv
// -----------------------------------------------------------------------------
// wbu_wbuf_arb
//   Write-back unit. Round-robin arbitration of NSRC producers onto the single
//   regfile write port through a DEPTH-entry in-order write buffer. It also
//   provides a combinational forwarding lookup over the pending entries.
//
//   Handshake: a transfer on source i happens on the rising edge of hclk when
//   src_valid[i] & src_ready[i]. src_ready is combinational and depends only
//   on the current grant and the registered fill level. On the regfile side a
//   write is retired on the edge where reg_wen & reg_wready.
//
// Ports
//   hclk, hrstn     clock (rising edge), asynchronous active-low reset
//   src_valid/ready per-source request / acceptance
//   src_rd/src_data per-source dest register / data, slice i at [i*AW +: AW]
//                   and [i*DW +: DW]
//   reg_wen/waddr/wdata/wready   regfile write port (head of buffer)
//   fwd_raddr/hit/data           forwarding lookup of pending writes
//   buf_count/full/empty         buffer occupancy
// -----------------------------------------------------------------------------
module wbu_wbuf_arb #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int DEPTH  = 4,
    parameter int FWD_EN = 1
) (
    input  logic                       hclk,
    input  logic                       hrstn,
    input  logic [NSRC-1:0]            src_valid,
    output logic [NSRC-1:0]            src_ready,
    input  logic [NSRC*AW-1:0]         src_rd,
    input  logic [NSRC*DW-1:0]         src_data,
    output logic                       reg_wen,
    output logic [AW-1:0]              reg_waddr,
    output logic [DW-1:0]              reg_wdata,
    input  logic                       reg_wready,
    input  logic [AW-1:0]              fwd_raddr,
    output logic                       fwd_hit,
    output logic [DW-1:0]              fwd_data,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    output logic                       buf_full,
    output logic                       buf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (NSRC > 1) ? $clog2(NSRC) : 1;

    // Buffer state
    logic [AW-1:0] r_mem_rd   [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [RW-1:0] r_rr_ptr;

    // Arbitration / control
    logic [NSRC-1:0] w_grant;
    logic [RW-1:0]   w_gnt_idx;
    logic            w_gnt_any;
    logic [AW-1:0]   w_gnt_rd;
    logic [DW-1:0]   w_gnt_data;
    logic            w_full;
    logic            w_empty;
    logic            w_hs;
    logic            w_push;
    logic            w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Round-robin: first valid source at or after r_rr_ptr wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (!w_gnt_any && src_valid[(int'(r_rr_ptr) + k) % NSRC]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = RW'((int'(r_rr_ptr) + k) % NSRC);
            end
        end
        w_grant = NSRC'(w_gnt_any) << w_gnt_idx;
    end

    assign w_gnt_rd   = src_rd[w_gnt_idx*AW +: AW];
    assign w_gnt_data = src_data[w_gnt_idx*DW +: DW];

    // hrstn gates ready so nothing is offered while the block is held in reset.
    assign src_ready = w_grant & {NSRC{~w_full & hrstn}};
    assign w_hs      = w_gnt_any & ~w_full & hrstn;
    // Writes to register 0 are accepted but discarded.
    assign w_push    = w_hs & (w_gnt_rd != '0);
    assign w_pop     = ~w_empty & reg_wready;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_hs) begin
                if (w_gnt_idx == RW'(NSRC - 1)) r_rr_ptr <= '0;
                else                            r_rr_ptr <= w_gnt_idx + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: entries are qualified by the pointers.
    always_ff @(posedge hclk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= w_gnt_rd;
            r_mem_data[r_wr_ptr] <= w_gnt_data;
        end
    end

    assign reg_wen   = ~w_empty;
    assign reg_waddr = reg_wen ? r_mem_rd[r_rd_ptr]   : '0;
    assign reg_wdata = reg_wen ? r_mem_data[r_rd_ptr] : '0;

    assign buf_count = r_count;
    assign buf_full  = w_full;
    assign buf_empty = w_empty;

    // Forwarding: walk oldest to youngest so the last match is the youngest.
    generate
        if (FWD_EN != 0) begin : g_fwd
            logic          w_fwd_hit;
            logic [DW-1:0] w_fwd_data;
            logic [PW-1:0] w_fidx;
            always_comb begin
                w_fwd_hit  = 1'b0;
                w_fwd_data = '0;
                w_fidx     = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    w_fidx = r_rd_ptr + PW'(k);
                    if ((CW'(k) < r_count) && (fwd_raddr != '0) &&
                        (r_mem_rd[w_fidx] == fwd_raddr)) begin
                        w_fwd_hit  = 1'b1;
                        w_fwd_data = r_mem_data[w_fidx];
                    end
                end
            end
            assign fwd_hit  = w_fwd_hit;
            assign fwd_data = w_fwd_data;
        end else begin : g_nofwd
            assign fwd_hit  = 1'b0;
            assign fwd_data = '0;
        end
    endgenerate

endmodule

// File: tb/tb_wbu_wbuf_arb.sv
// -----------------------------------------------------------------------------
// tb_wbu_wbuf_arb
//   Directed bench for wbu_wbuf_arb (default parameters). A table of
//   one-cycle vectors covers single write, x0 drop, round-robin and
//   forwarding; hand-written sequences cover full/backpressure and async
//   reset with entries pending.
// -----------------------------------------------------------------------------
module tb_wbu_wbuf_arb;

    // ---------------- clock / reset ----------------
    logic        hclk = 1'b0;
    logic        hrstn;
    always #5 hclk = ~hclk;

    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [9:0]  src_rd;
    logic [63:0] src_data;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wready;
    logic [4:0]  fwd_raddr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  buf_count;
    logic        buf_full;
    logic        buf_empty;

    wbu_wbuf_arb dut (
        .hclk       (hclk),
        .hrstn      (hrstn),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_rd     (src_rd),
        .src_data   (src_data),
        .reg_wen    (reg_wen),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .reg_wready (reg_wready),
        .fwd_raddr  (fwd_raddr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .buf_count  (buf_count),
        .buf_full   (buf_full),
        .buf_empty  (buf_empty)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic [4:0] rd1, input logic [31:0] d1,
                         input logic wr, input logic [4:0] fa);
        src_valid  = v;
        src_rd     = {rd1, rd0};
        src_data   = {d1, d0};
        reg_wready = wr;
        fwd_raddr  = fa;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic        wready;
        logic [4:0]  fraddr;
        logic [1:0]  e_ready;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_hit;
        logic [31:0] e_fd;
        logic [2:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, input logic [4:0] rd0, input logic [31:0] d0,
                                input logic [4:0] rd1, input logic [31:0] d1,
                                input logic wr, input logic [4:0] fa,
                                input logic [1:0] er, input logic ew, input logic [4:0] ea,
                                input logic [31:0] ed, input logic eh, input logic [31:0] ef,
                                input logic [2:0] ec);
        vec_t t;
        t.valid = v;  t.rd0 = rd0; t.d0 = d0; t.rd1 = rd1; t.d1 = d1;
        t.wready = wr; t.fraddr = fa;
        t.e_ready = er; t.e_wen = ew; t.e_waddr = ea; t.e_wdata = ed;
        t.e_hit = eh; t.e_fd = ef; t.e_cnt = ec;
        return t;
    endfunction

    localparam int NV = 21;
    vec_t vecs[NV];

    initial begin
        // state-dependent: each row assumes the rows before it have run
        vecs[0]  = mk(2'b00, 0, 0, 0, 0, 1, 0,  2'b00, 0, 0, 0, 0, 0, 0);
        // single write of reg 5; same-cycle request not forwarded
        vecs[1]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 1, 5,  2'b01, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(2'b00, 0, 0, 0, 0, 1, 5,  2'b00, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
        vecs[3]  = mk(2'b00, 0, 0, 0, 0, 1, 5,  2'b00, 0, 0, 0, 0, 0, 0);
        // x0 drops from each source (rr_ptr 1 -> 1 -> 0)
        vecs[4]  = mk(2'b01, 0, 32'h1234, 0, 0, 1, 0,  2'b01, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(2'b10, 0, 0, 0, 32'h5678, 1, 0,  2'b10, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(2'b00, 0, 0, 0, 0, 1, 0,  2'b00, 0, 0, 0, 0, 0, 0);
        // round robin, both valid
        vecs[7]  = mk(2'b11, 1, 32'hA0, 2, 32'hB0, 1, 1,  2'b01, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(2'b11, 1, 32'hA1, 2, 32'hB1, 1, 1,  2'b10, 1, 1, 32'hA0, 1, 32'hA0, 1);
        vecs[9]  = mk(2'b11, 1, 32'hA2, 2, 32'hB2, 1, 2,  2'b01, 1, 2, 32'hB1, 1, 32'hB1, 1);
        vecs[10] = mk(2'b11, 1, 32'hA3, 2, 32'hB3, 1, 1,  2'b10, 1, 1, 32'hA2, 1, 32'hA2, 1);
        vecs[11] = mk(2'b00, 0, 0, 0, 0, 1, 2,  2'b00, 1, 2, 32'hB3, 1, 32'hB3, 1);
        vecs[12] = mk(2'b00, 0, 0, 0, 0, 1, 0,  2'b00, 0, 0, 0, 0, 0, 0);
        // forwarding: two writes to reg 7, regfile stalled
        vecs[13] = mk(2'b01, 7, 32'h11, 0, 0, 0, 7,  2'b01, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(2'b01, 7, 32'h22, 0, 0, 0, 7,  2'b01, 1, 7, 32'h11, 1, 32'h11, 1);
        vecs[15] = mk(2'b00, 0, 0, 0, 0, 0, 7,  2'b00, 1, 7, 32'h11, 1, 32'h22, 2);
        vecs[16] = mk(2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 1, 7, 32'h11, 0, 0, 2);
        vecs[17] = mk(2'b00, 0, 0, 0, 0, 0, 3,  2'b00, 1, 7, 32'h11, 0, 0, 2);
        vecs[18] = mk(2'b00, 0, 0, 0, 0, 1, 7,  2'b00, 1, 7, 32'h11, 1, 32'h22, 2);
        vecs[19] = mk(2'b00, 0, 0, 0, 0, 1, 7,  2'b00, 1, 7, 32'h22, 1, 32'h22, 1);
        vecs[20] = mk(2'b00, 0, 0, 0, 0, 1, 0,  2'b00, 0, 0, 0, 0, 0, 0);
    end

    // ---------------- test ----------------
    initial begin
        hrstn = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 5'd0);
        #2;
        chk("reset_state", {src_ready, reg_wen, reg_waddr, reg_wdata, fwd_hit, fwd_data,
                            buf_count, buf_empty, buf_full},
                           {2'b00, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 1'b0});
        tick();
        tick();
        hrstn = 1'b1;
        tick();

        // table-driven vectors: outputs checked before the edge that applies them
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].rd0, vecs[i].d0, vecs[i].rd1, vecs[i].d1,
                  vecs[i].wready, vecs[i].fraddr);
            #2;
            chk($sformatf("vec%0d", i),
                {src_ready, reg_wen, reg_waddr, reg_wdata, fwd_hit, fwd_data, buf_count},
                {vecs[i].e_ready, vecs[i].e_wen, vecs[i].e_waddr, vecs[i].e_wdata,
                 vecs[i].e_hit, vecs[i].e_fd, vecs[i].e_cnt});
            tick();
        end

        // full / backpressure: four writes with regfile stalled
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 5'(10 + i), 32'h100 + i, 0, 0, 1'b0, 5'd0);
            exp_q.push_back({5'(10 + i), 32'h100 + i});
            #2;
            chk($sformatf("full_push%0d_rdy", i), src_ready, 2'b01);
            tick();
        end
        drive(2'b01, 5'd14, 32'h104, 0, 0, 1'b0, 5'd0);
        #2;
        chk("full_flags", {buf_full, buf_empty, buf_count, src_ready}, {1'b1, 1'b0, 3'd4, 2'b00});
        tick();
        #2;
        chk("full_hold", {buf_count, reg_wen, reg_waddr, reg_wdata}, {3'd4, 1'b1, 5'd10, 32'h100});
        // release: the pop in this cycle must not open the door to a push
        reg_wready = 1'b1;
        #1;
        chk("full_pop_no_rdy", src_ready, 2'b00);
        for (int i = 0; i < 4; i++) begin
            logic [36:0] e;
            e = exp_q.pop_front();
            chk($sformatf("commit%0d", i), {reg_wen, reg_waddr, reg_wdata}, {1'b1, e});
            tick();
            src_valid = 2'b00;
            #2;
        end
        chk("drained", {buf_count, buf_empty, reg_wen, reg_waddr}, {3'd0, 1'b1, 1'b0, 5'd0});
        tick();

        // async reset with three entries pending
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 5'(20 + i), 32'h200 + i, 0, 0, 1'b0, 5'd20);
            tick();
        end
        #2;
        chk("pre_reset_count", {buf_count, fwd_hit}, {3'd3, 1'b1});
        hrstn = 1'b0;
        #1;
        chk("async_reset", {src_ready, reg_wen, reg_waddr, reg_wdata, fwd_hit, fwd_data,
                            buf_count, buf_empty, buf_full},
                           {2'b00, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 1'b0});
        src_valid = 2'b00;
        tick();
        tick();
        hrstn = 1'b1;
        tick();
        #2;
        chk("post_reset", {buf_empty, reg_wen, fwd_hit, buf_count}, {1'b1, 1'b0, 1'b0, 3'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
